// File: rtl/saturation_ctrl_pkg.sv
// Shared types and constants for the saturation coefficient scheduler.
package saturation_ctrl_pkg;

  localparam int SAT_COE_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RAMP  = 2'd2
  } sat_ctrl_state_t;

  localparam logic [1:0] SAT_ADR_SAT   = 2'd0;
  localparam logic [1:0] SAT_ADR_YCOE0 = 2'd1;
  localparam logic [1:0] SAT_ADR_YCOE1 = 2'd2;
  localparam logic [1:0] SAT_ADR_YCOE2 = 2'd3;

  typedef struct packed {
    logic [SAT_COE_W-1:0] sat;
    logic [SAT_COE_W-1:0] ycoe0;
    logic [SAT_COE_W-1:0] ycoe1;
    logic [SAT_COE_W-1:0] ycoe2;
  } coe_set_t;

endpackage

// File: rtl/saturation_ctrl_if.sv
// Host configuration port: staging writes, commit strobe and busy status.
interface saturation_ctrl_if #(
  parameter int COE_WIDTH = 16
);
  logic                 cfg_wr_i;
  logic [1:0]           cfg_adr_i;
  logic [COE_WIDTH-1:0] cfg_dat_i;
  logic                 cfg_commit_i;
  logic                 cfg_busy_o;

  modport master (
    output cfg_wr_i, cfg_adr_i, cfg_dat_i, cfg_commit_i,
    input  cfg_busy_o
  );

  modport slave (
    input  cfg_wr_i, cfg_adr_i, cfg_dat_i, cfg_commit_i,
    output cfg_busy_o
  );
endinterface

// File: rtl/saturation_ctrl_sync_edge_det.sv
// Registered rising-edge detector; the delayed copy resets to 0.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  output logic o_edge
);
  logic r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_q <= 1'b0;
    else     r_q <= i_sig;
  end

  assign o_edge = i_sig & ~r_q;
endmodule

// File: rtl/saturation_ctrl.sv
// Frame-synchronous coefficient scheduler: luma weights switch at frame start,
// saturation ramps toward its target by a bounded step per frame.
module saturation_ctrl
  import saturation_ctrl_pkg::*;
#(
  parameter int COE_WIDTH     = SAT_COE_W,
  parameter int RAMP_STEP     = 4,
  parameter int SAT_DEFAULT   = 64,
  parameter int YCOE0_DEFAULT = 19,
  parameter int YCOE1_DEFAULT = 37,
  parameter int YCOE2_DEFAULT = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  saturation_ctrl_if.slave     cfg,
  input  logic                 vs_i,
  output logic [COE_WIDTH-1:0] saturation_o,
  output logic [COE_WIDTH-1:0] ycoe0_o,
  output logic [COE_WIDTH-1:0] ycoe1_o,
  output logic [COE_WIDTH-1:0] ycoe2_o,
  output logic                 update_o,
  output logic [1:0]           state_o
);

  localparam coe_set_t SET_DEFAULT = '{
    sat:   SAT_COE_W'(SAT_DEFAULT),
    ycoe0: SAT_COE_W'(YCOE0_DEFAULT),
    ycoe1: SAT_COE_W'(YCOE1_DEFAULT),
    ycoe2: SAT_COE_W'(YCOE2_DEFAULT)
  };
  localparam logic [COE_WIDTH:0] STEP_W = (COE_WIDTH+1)'(RAMP_STEP);

  sat_ctrl_state_t      r_state, w_state_nxt;
  coe_set_t             r_stage, r_pend, r_act;
  logic [COE_WIDTH-1:0] r_target;
  logic                 r_pending;
  logic                 r_update;
  logic                 r_busy;

  logic                 w_fe;
  logic                 w_step;
  logic                 w_load;
  logic [COE_WIDTH-1:0] w_tgt;
  logic [COE_WIDTH-1:0] w_sat_nxt;

  function automatic logic [COE_WIDTH-1:0] sat_step(
    input logic [COE_WIDTH-1:0] cur,
    input logic [COE_WIDTH-1:0] tgt
  );
    logic signed [COE_WIDTH:0] d;
    logic [COE_WIDTH:0]        mag;
    d   = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    mag = d[COE_WIDTH] ? 
          (COE_WIDTH+1)'(-d) : (COE_WIDTH+1)'(d);
    if (RAMP_STEP == 0 || mag <= STEP_W) sat_step = tgt;
    else if (d[COE_WIDTH])               sat_step = cur - STEP_W[COE_WIDTH-1:0];
    else                                 sat_step = cur + STEP_W[COE_WIDTH-1:0];
  endfunction

  sync_edge_det u_vs_edge (
    .clk    (clk),
    .rst    (rst),
    .i_sig  (vs_i),
    .o_edge (w_fe)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_step      = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE:  if (r_pending) w_state_nxt = ST_ARMED;
      ST_ARMED: begin
        w_step = w_fe;
        w_load = w_fe;
      end
      ST_RAMP: begin
        w_step = w_fe;
        w_load = w_fe & r_pending;
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
    w_tgt     = w_load ? r_pend.sat : r_target;
    w_sat_nxt = sat_step(r_act.sat, w_tgt);
    if (w_step) w_state_nxt = (w_sat_nxt == w_tgt) ? ST_IDLE : ST_RAMP;
  end

  // A commit landing on the same edge as a load wins: the old set is consumed
  // while the new one stays pending for the following frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stage   <= SET_DEFAULT;
      r_pend    <= SET_DEFAULT;
      r_act     <= SET_DEFAULT;
      r_target  <= SET_DEFAULT.sat;
      r_pending <= 1'b0;
      r_update  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      if (cfg.cfg_wr_i) begin
        case (cfg.cfg_adr_i)
          SAT_ADR_SAT:   r_stage.sat   <= cfg.cfg_dat_i;
          SAT_ADR_YCOE0: r_stage.ycoe0 <= cfg.cfg_dat_i;
          SAT_ADR_YCOE1: r_stage.ycoe1 <= cfg.cfg_dat_i;
          default:       r_stage.ycoe2 <= cfg.cfg_dat_i;
        endcase
      end
      if (cfg.cfg_commit_i) begin
        r_pend    <= r_stage;
        r_pending <= 1'b1;
      end else if (w_load) begin
        r_pending <= 1'b0;
      end
      if (w_load) begin
        r_act.ycoe0 <= r_pend.ycoe0;
        r_act.ycoe1 <= r_pend.ycoe1;
        r_act.ycoe2 <= r_pend.ycoe2;
        r_target    <= r_pend.sat;
      end
      if (w_step) r_act.sat <= w_sat_nxt;
      r_update <= w_step;
      r_busy   <= (w_state_nxt != ST_IDLE) | cfg.cfg_commit_i | (r_pending & ~w_load);
    end
  end

  assign saturation_o   = r_act.sat;
  assign ycoe0_o        = r_act.ycoe0;
  assign ycoe1_o        = r_act.ycoe1;
  assign ycoe2_o        = r_act.ycoe2;
  assign update_o       = r_update;
  assign state_o        = r_state;
  assign cfg.cfg_busy_o = r_busy;

endmodule
